// File: rtl/pwm_capture_pkg.sv
// pwm_capture_defs: definitions shared by the PWM capture block.
//   state_e     - capture FSM states (IDLE / ACTIVE / INACTIVE)
//   DEF_CNT_W   - default active-time / period counter width
//   DEF_TIMEOUT - default number of edge-free cycles before no_signal
//   SYNC_DEPTH  - input synchronizer depth
//   FILT_LEN    - glitch filter length (consecutive equal samples)
package pwm_capture_defs;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    INACTIVE = 2'd2
  } state_e;

  localparam int unsigned DEF_CNT_W   = 10;
  localparam int unsigned DEF_TIMEOUT = 4096;
  localparam int unsigned SYNC_DEPTH  = 2;
  localparam int unsigned FILT_LEN    = 3;

endpackage

// File: rtl/pwm_capture_sync.sv
// pwm_capture_sync: input conditioning for pwm_capture.
//   Synchronizes the asynchronous PWM pin, normalises polarity so that
//   act_o = 1 means "active phase", and produces single-cycle rise/fall
//   strobes on act_o. Optional glitch filter: PWM_CAPTURE_GLITCH_FILTER_EN.
// Ports:
//   clk_i   in  system clock
//   rst_ni  in  asynchronous active-low reset
//   pwm_i   in  asynchronous PWM pin
//   act_o   out normalised, conditioned input level (1 = active phase)
//   rise_o  out one-cycle strobe, act_o went inactive -> active
//   fall_o  out one-cycle strobe, act_o went active -> inactive
module pwm_capture_sync
  import pwm_capture_defs::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pwm_i,
  output logic act_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic IDLE_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int unsigned ARM_LEN = SYNC_DEPTH + 1 + (FILT_LEN - 1);
`else
  localparam int unsigned ARM_LEN = SYNC_DEPTH + 1;
`endif

  logic [SYNC_DEPTH-1:0] sync_q;
  logic [ARM_LEN-1:0]    arm_q;
  logic                  sync_act;
  logic                  act;
  logic                  act_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_DEPTH{IDLE_LVL}};
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], pwm_i};
    end
  end

  assign sync_act = sync_q[SYNC_DEPTH-1] ^ ACTIVE_LOW;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [FILT_LEN-2:0] hist_q;
  logic                stable;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
    end else begin
      hist_q <= {hist_q[FILT_LEN-3:0], sync_act};
    end
  end

  // The current sample plus the stored history must all agree before the
  // conditioned level is allowed to follow the pin.
  assign stable = sync_act ? (&hist_q) : ~(|hist_q);
  assign act    = stable ? sync_act : act_prev_q;
`else
  assign act = sync_act;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_prev_q <= 1'b0;
      arm_q      <= '0;
    end else begin
      act_prev_q <= act;
      arm_q      <= {arm_q[ARM_LEN-2:0], 1'b1};
    end
  end

  // Edges are suppressed until the pipeline has flushed its reset preset,
  // so a pin already active at reset release does not look like a rise.
  assign act_o  = act;
  assign rise_o = arm_q[ARM_LEN-1] &  act & ~act_prev_q;
  assign fall_o = arm_q[ARM_LEN-1] & ~act &  act_prev_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform, publishing the active-phase
// length and period (in clk cycles) once per PWM period.
// Optional glitch filter in the input path: PWM_CAPTURE_GLITCH_FILTER_EN.
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous active-low reset
//   pwm_in     in  asynchronous PWM input
//   level_out  out active-phase length of the last complete period
//   period_out out length of the last complete period (low CNT_W bits)
//   meas_valid out one-cycle pulse when level_out / period_out update
//   overflow   out sticky counter-saturation flag
//   no_signal  out input static for TIMEOUT cycles
module pwm_capture
  import pwm_capture_defs::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] level_out,
  output logic [CNT_W-1:0] period_out,
  output logic             meas_valid,
  output logic             overflow,
  output logic             no_signal
);

  localparam logic [CNT_W:0] SAT = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};
  localparam int unsigned    TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic act;
  logic rise;
  logic fall;

  pwm_capture_sync #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .pwm_i  (pwm_in),
    .act_o  (act),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_e          state_q;
  logic [CNT_W:0]  act_cnt_q;
  logic [CNT_W:0]  per_cnt_q;
  logic            act_ovf_q;
  logic            per_ovf_q;
  logic [TO_W-1:0] idle_q;

  logic [CNT_W:0]  act_cnt_d;
  logic [CNT_W:0]  per_cnt_d;
  logic            act_at_sat;
  logic            per_at_sat;
  logic            timeout;

  // A counter sitting at SAT holds an exact 2^CNT_W count; only a further
  // increment request counts as saturation, so an exact 2^CNT_W period
  // wraps to 0 without flagging overflow.
  assign act_at_sat = (act_cnt_q == SAT);
  assign per_at_sat = (per_cnt_q == SAT);
  assign act_cnt_d  = act_at_sat ? SAT : act_cnt_q + ONE;
  assign per_cnt_d  = per_at_sat ? SAT : per_cnt_q + ONE;

  // Any edge restarts the idle count, so a coincident rise beats timeout.
  assign timeout = !rise && !fall && (idle_q == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      act_cnt_q  <= '0;
      per_cnt_q  <= '0;
      act_ovf_q  <= 1'b0;
      per_ovf_q  <= 1'b0;
      idle_q     <= '0;
      level_out  <= '0;
      period_out <= '0;
      meas_valid <= 1'b0;
      overflow   <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      if (rise || fall) begin
        idle_q <= '0;
      end else if (idle_q != TO_MAX) begin
        idle_q <= idle_q + 1'b1;
      end

      if (rise) begin
        no_signal <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_q   <= ACTIVE;
            act_cnt_q <= ONE;
            per_cnt_q <= ONE;
            act_ovf_q <= 1'b0;
            per_ovf_q <= 1'b0;
          end
        end
        ACTIVE: begin
          per_cnt_q <= per_cnt_d;
          if (per_at_sat) begin
            per_ovf_q <= 1'b1;
            overflow  <= 1'b1;
          end
          if (fall) begin
            state_q <= INACTIVE;
          end else begin
            act_cnt_q <= act_cnt_d;
            if (act_at_sat) begin
              act_ovf_q <= 1'b1;
              overflow  <= 1'b1;
            end
          end
        end
        INACTIVE: begin
          if (rise) begin
            level_out  <= act_ovf_q ? '1 : act_cnt_q[CNT_W-1:0];
            period_out <= per_ovf_q ? '1 : per_cnt_q[CNT_W-1:0];
            meas_valid <= 1'b1;
            state_q    <= ACTIVE;
            act_cnt_q  <= ONE;
            per_cnt_q  <= ONE;
            act_ovf_q  <= 1'b0;
            per_ovf_q  <= 1'b0;
          end else begin
            per_cnt_q <= per_cnt_d;
            if (per_at_sat) begin
              per_ovf_q <= 1'b1;
              overflow  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (timeout) begin
        no_signal  <= 1'b1;
        state_q    <= IDLE;
        meas_valid <= 1'b1;
        level_out  <= act ? '1 : '0;
        period_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed self-checking bench for pwm_capture
// (CNT_W = 10, ACTIVE_LOW = 1, TIMEOUT = 4096).
module tb_pwm_capture;

  logic       clk;
  logic       rst_n;
  logic       pwm;
  logic [9:0] level_out;
  logic [9:0] period_out;
  logic       meas_valid;
  logic       overflow;
  logic       no_signal;

  int total;
  int bad;
  int cyc;
  int cap_cnt;
  int cap_cyc;
  int cap_level;
  int cap_period;
  int base;
  int r2;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  pwm_capture #(
    .CNT_W      (10),
    .ACTIVE_LOW (1'b1),
    .TIMEOUT    (4096)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .pwm_in     (pwm),
    .level_out  (level_out),
    .period_out (period_out),
    .meas_valid (meas_valid),
    .overflow   (overflow),
    .no_signal  (no_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    cap_cnt    = 0;
    cap_cyc    = 0;
    cap_level  = 0;
    cap_period = 0;
  end

  always @(negedge clk) begin
    if (meas_valid) begin
      cap_cnt    <= cap_cnt + 1;
      cap_cyc    <= cyc;
      cap_level  <= int'(level_out);
      cap_period <= int'(period_out);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Hold the pin at v for n clocks; returns #1 after a rising edge.
  task automatic hold(input logic v, input int n);
    pwm = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One PWM period: active (pin low) for a cycles, inactive for i cycles.
  task automatic per(input int a, input int i);
    hold(1'b0, a);
    hold(1'b1, i);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    pwm   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_level",    int'(level_out),  0);
    check("rst_period",   int'(period_out), 0);
    check("rst_valid",    int'(meas_valid), 0);
    check("rst_overflow", int'(overflow),   0);
    check("rst_nosig",    int'(no_signal),  0);

    rst_n = 1'b1;
    hold(1'b1, 10);

    // 7 active / 13 inactive
    base = cap_cnt;
    per(7, 13);
    r2 = cyc;
    per(7, 13);
    check("p7_latency", cap_cyc - r2, LAT);
    per(7, 13);
    per(7, 13);
    check("p7_count",  cap_cnt - base, 3);
    check("p7_level",  cap_level,  7);
    check("p7_period", cap_period, 20);

    // generator loopback, level 300 of 1024
    repeat (3) per(300, 724);
    check("g300_level",    cap_level,  300);
    check("g300_period",   cap_period, 0);
    check("g300_overflow", int'(overflow),  0);
    check("g300_nosig",    int'(no_signal), 0);

    // input static long enough to time out
    base = cap_cnt;
    hold(1'b1, 4100);
    check("to_count",  cap_cnt - base, 1);
    check("to_level",  cap_level,  0);
    check("to_period", cap_period, 0);
    check("to_nosig",  int'(no_signal), 1);
    hold(1'b0, 7);
    check("to_clear", int'(no_signal), 0);
    hold(1'b1, 13);
    per(7, 13);
    check("to_count2", cap_cnt - base, 2);
    check("to_level2", cap_level,  7);
    check("to_period2", cap_period, 20);

`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    // single-cycle active phase
    per(1, 19);
    per(1, 19);
    check("p1_level",  cap_level,  1);
    check("p1_period", cap_period, 20);
`endif

    // 1500-cycle period, 1200 active: both counters saturate
    per(1200, 300);
    hold(1'b0, 50);
    check("ovf_level",  cap_level,  1023);
    check("ovf_period", cap_period, 1023);
    check("ovf_flag",   int'(overflow), 1);

    // reset in the middle of an active phase
    rst_n = 1'b0;
    #1;
    check("mid_level",    int'(level_out),  0);
    check("mid_period",   int'(period_out), 0);
    check("mid_valid",    int'(meas_valid), 0);
    check("mid_overflow", int'(overflow),   0);
    check("mid_nosig",    int'(no_signal),  0);
    hold(1'b0, 3);
    rst_n = 1'b1;
    base = cap_cnt;
    hold(1'b0, 100);
    hold(1'b1, 13);
    per(7, 13);
    per(7, 13);
    check("mid_count",  cap_cnt - base, 1);
    check("mid_level2", cap_level,  7);
    check("mid_period2", cap_period, 20);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // 2-cycle spurious pulse inside the inactive phase must be ignored
    base = cap_cnt;
    repeat (2) begin
      hold(1'b0, 7);
      hold(1'b1, 5);
      hold(1'b0, 2);
      hold(1'b1, 6);
    end
    hold(1'b0, 7);
    check("gl_count",  cap_cnt - base, 3);
    check("gl_level",  cap_level,  7);
    check("gl_period", cap_period, 20);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
